// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit.
package fetch_unit_pkg;

    localparam int unsigned INSTR_SIZE = 32;
    localparam int unsigned PC_SIZE    = 32;

    localparam logic [INSTR_SIZE-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [PC_SIZE-1:0]    RESET_PC_DEFAULT = 32'h0000_0000;

    // One queue entry: the PC the word was fetched from and the word itself.
    typedef struct packed {
        logic [PC_SIZE-1:0]    pc;
        logic [INSTR_SIZE-1:0] instr;
    } fq_entry_t;

    // Force an address onto a 32-bit word boundary.
    function automatic logic [PC_SIZE-1:0] align_word(input logic [PC_SIZE-1:0] addr);
        return {addr[PC_SIZE-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular instruction queue with flush; head is visible combinationally.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_flush,
    input  fq_entry_t                    i_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH):0]       o_count,
    output fq_entry_t                    o_head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    fq_entry_t         r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == DEPTH_W);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    // A full queue may still take a push in the same cycle its head leaves.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage, pointers and occupancy; flush discards everything at once.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The request throttle upstream must make this impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!nrst)
        !(i_push && !i_flush && o_full && !i_pop))
        else $error("fetch_fifo: push into full queue");

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, redirect/flush handling,
// and a small queue feeding decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [PC_SIZE-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned        FQ_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [PC_SIZE-1:0]    redirect_pc,
    output logic                  imem_req,
    output logic [PC_SIZE-1:0]    imem_addr,
    input  logic                  imem_rvalid,
    input  logic [INSTR_SIZE-1:0] imem_rdata,
    output logic [INSTR_SIZE-1:0] instr_out,
    output logic [PC_SIZE-1:0]    pc_out,
    output logic                  instr_valid
);

    localparam int unsigned CW      = $clog2(FQ_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FQ_DEPTH);

    logic [PC_SIZE-1:0] r_fetch_pc;
    logic [PC_SIZE-1:0] r_req_pc;
    logic               r_inflight;
    logic               r_discard;

    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [CW-1:0]      w_count;
    fq_entry_t          w_head;
    fq_entry_t          w_push_data;
    logic [CW:0]        w_occ;
    logic               w_req;

    // Responses are only accepted for a live, non-cancelled request; a
    // redirect in the same cycle kills the word too.
    assign w_push      = imem_rvalid && r_inflight && !r_discard && !redirect;
    assign w_pop       = !stall && !w_empty && !redirect;
    assign w_push_data = '{pc: r_req_pc, instr: imem_rdata};

    // Queue occupancy after this cycle's push/pop plus the slot a new request reserves.
    always_comb begin
        w_occ = {1'b0, w_count} + {{CW{1'b0}}, 1'b1};
        if (w_push) begin
            w_occ = w_occ + {{CW{1'b0}}, 1'b1};
        end else begin
            w_occ = w_occ;
        end
        if (w_pop) begin
            w_occ = w_occ - {{CW{1'b0}}, 1'b1};
        end else begin
            w_occ = w_occ;
        end
    end

    // Issue only when the bus is free (or freeing this cycle) and a slot is reserved.
    assign w_req = nrst && !redirect && (!r_inflight || imem_rvalid)
                   && (w_occ <= DEPTH_W) && !(w_full && !w_pop);

    assign imem_req  = w_req;
    assign imem_addr = r_fetch_pc;

    // Fetch PC, outstanding-request tracking and stale-response discard.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_fetch_pc <= align_word(RESET_PC);
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
            r_discard  <= 1'b0;
        end else if (redirect) begin
            r_fetch_pc <= align_word(redirect_pc);
            // A request still on the bus must have its answer thrown away.
            r_inflight <= r_inflight && !imem_rvalid;
            r_discard  <= r_inflight && !imem_rvalid;
        end else begin
            if (w_req) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_req_pc   <= r_fetch_pc;
                r_inflight <= 1'b1;
            end else if (imem_rvalid) begin
                r_inflight <= 1'b0;
            end else begin
                r_inflight <= r_inflight;
            end
            if (imem_rvalid && r_discard) begin
                r_discard <= 1'b0;
            end else begin
                r_discard <= r_discard;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .i_data  (w_push_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_head  (w_head)
    );

    // Present the queue head to decode, or a NOP when nothing is queued.
    always_comb begin
        instr_valid = !w_empty;
        if (w_empty) begin
            instr_out = NOP_INSTR;
            pc_out    = '0;
        end else begin
            instr_out = w_head.instr;
            pc_out    = w_head.pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural instruction memory and
// an in-order scoreboard of the words decode should see.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;

    fetch_unit #(
        .RESET_PC (TB_RESET_PC),
        .FQ_DEPTH (2)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .instr_valid (instr_valid)
    );

    always #5 clk = ~clk;

    int          pass_cnt = 0;
    int          chk_cnt  = 0;

    // memory model / scoreboard state
    logic [63:0] exp_q[$];
    bit          have_pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_cnt  = 0;
    int          pend_epoch = 0;
    int          epoch = 0;
    int          lat = 1;
    logic [31:0] exp_pc = TB_RESET_PC;
    logic        last_req = 1'b0;
    logic [31:0] last_addr = 32'h0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return ~a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs and the memory response, check outputs,
    // advance the model. Entered and left on a falling edge.
    task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc);
        logic        resp;
        logic [63:0] e;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        resp = have_pend && (pend_cnt == 0);
        if (have_pend && !resp) pend_cnt--;
        imem_rvalid = resp;
        imem_rdata  = resp ? mem_data(pend_addr) : 32'hDEAD_BEEF;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            check("instr_valid", {31'h0, instr_valid}, 32'h1);
            check("instr_out", instr_out, e[31:0]);
            check("pc_out", pc_out, e[63:32]);
        end else begin
            check("instr_valid_empty", {31'h0, instr_valid}, 32'h0);
            check("instr_out_nop", instr_out, NOP_INSTR);
            check("pc_out_zero", pc_out, 32'h0);
        end
        if (rd || !nrst) check("imem_req_blocked", {31'h0, imem_req}, 32'h0);
        last_req  = imem_req;
        last_addr = imem_addr;
        if (imem_req === 1'b1) begin
            check("imem_addr", imem_addr, exp_pc);
            check("one_outstanding", {31'h0, (have_pend && !resp)}, 32'h0);
        end
        if (nrst && !rd && !st && exp_q.size() != 0) void'(exp_q.pop_front());
        if (resp) begin
            if (nrst && !rd && pend_epoch == epoch)
                exp_q.push_back({pend_addr, mem_data(pend_addr)});
            have_pend = 1'b0;
        end
        if (rd) begin
            exp_q.delete();
            epoch++;
            exp_pc = {rpc[31:2], 2'b00};
        end
        if (imem_req === 1'b1 && nrst) begin
            have_pend  = 1'b1;
            pend_addr  = imem_addr;
            pend_cnt   = lat - 1;
            pend_epoch = epoch;
            exp_pc     = exp_pc + 32'd4;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Assert reset, check outputs react immediately, hold for n cycles, release.
    task automatic apply_reset(input int n);
        nrst = 1'b0;
        #1;
        check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_instr_out", instr_out, NOP_INSTR);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_imem_req", {31'h0, imem_req}, 32'h0);
        exp_q.delete();
        epoch++;
        exp_pc = TB_RESET_PC;
        repeat (n) cycle(1'b0, 1'b0, 32'h0);
        nrst = 1'b1;
        cycle(1'b0, 1'b0, 32'h0);
        check("first_req_after_reset", {31'h0, last_req}, 32'h1);
        check("first_addr_after_reset", last_addr, TB_RESET_PC);
    endtask

    initial begin
        bit          found;
        bit          saw_top;
        logic [31:0] h_instr;
        logic [31:0] h_pc;

        #2;
        apply_reset(3);

        // streaming with 1-cycle memory, no stall: addresses 0,4,8,...
        lat = 1;
        repeat (12) cycle(1'b0, 1'b0, 32'h0);

        // stall until the queue is full, then hold for four cycles
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 2) begin found = 1'b1; break; end
            cycle(1'b1, 1'b0, 32'h0);
        end
        check("stall_fill_timeout", {31'h0, found}, 32'h1);
        h_instr = instr_out;
        h_pc    = pc_out;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 32'h0);
            check("stall_instr_const", instr_out, h_instr);
            check("stall_pc_const", pc_out, h_pc);
            check("stall_no_req", {31'h0, last_req}, 32'h0);
        end
        repeat (8) cycle(1'b0, 1'b0, 32'h0);

        // redirect while the 0x8 request is outstanding on a 3-cycle memory
        lat = 3;
        cycle(1'b0, 1'b1, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (have_pend && pend_addr == 32'h8 && pend_cnt > 0) begin found = 1'b1; break; end
            cycle(1'b0, 1'b0, 32'h0);
        end
        check("inflight8_timeout", {31'h0, found}, 32'h1);
        cycle(1'b0, 1'b1, 32'h0000_0103);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            if (last_req === 1'b1) begin found = 1'b1; break; end
        end
        check("redir_req_timeout", {31'h0, found}, 32'h1);
        check("redir_first_addr", last_addr, 32'h0000_0100);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (instr_valid === 1'b1) begin found = 1'b1; break; end
            cycle(1'b0, 1'b0, 32'h0);
        end
        check("redir_valid_timeout", {31'h0, found}, 32'h1);
        check("redir_first_pc", pc_out, 32'h0000_0100);

        // random stalls on the slow memory
        for (int i = 0; i < 24; i++) cycle(($urandom_range(0, 3) == 0), 1'b0, 32'h0);

        // redirect in the very cycle a response arrives
        lat = 2;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (have_pend && pend_cnt == 0) begin found = 1'b1; break; end
            cycle(1'b0, 1'b0, 32'h0);
        end
        check("rvalid_sync_timeout", {31'h0, found}, 32'h1);
        cycle(1'b0, 1'b1, 32'h0000_0040);
        check("redir_rvalid_valid", {31'h0, instr_valid}, 32'h0);
        check("redir_rvalid_nop", instr_out, NOP_INSTR);
        repeat (8) cycle(1'b0, 1'b0, 32'h0);

        // fetch PC wraps from 0xFFFF_FFFC to 0
        lat = 1;
        cycle(1'b0, 1'b1, 32'hFFFF_FFF8);
        saw_top = 1'b0;
        found   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            if (saw_top && last_req === 1'b1) begin
                check("wrap_addr", last_addr, 32'h0000_0000);
                found = 1'b1;
                break;
            end
            if (last_req === 1'b1 && last_addr == 32'hFFFF_FFFC) saw_top = 1'b1;
        end
        check("wrap_timeout", {31'h0, found}, 32'h1);
        repeat (6) cycle(1'b0, 1'b0, 32'h0);

        // reset mid-stream with a request outstanding and a word queued
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (have_pend && pend_cnt > 0 && exp_q.size() != 0) begin found = 1'b1; break; end
            cycle(1'b0, 1'b0, 32'h0);
        end
        check("midrst_setup_timeout", {31'h0, found}, 32'h1);
        check("midrst_pre_valid", {31'h0, instr_valid}, 32'h1);
        apply_reset(4);
        repeat (15) cycle(1'b0, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
